// File: rtl/wb_arbiter_cp4.sv
// wb_arbiter_cp4: merges pipeline and long-latency results onto the register-file write port and tracks outstanding destinations
module wb_arbiter_cp4 #(
    parameter int STARVE_MAX      = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_wa,
    input  logic [31:0] pipe_wd,
    output logic        pipe_accept,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_wa,
    input  logic [31:0] lu_wd,
    input  logic        issue_valid,
    input  logic [4:0]  issue_wa,
    output logic        issue_ready,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic        busy1,
    output logic        busy2,
    output logic        stall_req,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0]    starve;
    logic [CNT_W-1:0] outstanding;
    logic [31:0]      busy, set_mask, clr_mask;
    logic             pipe_eff, pipe_wr, lu_hs, lu_wr, starving, issue_acc;
    // arbitration: pipeline first unless a starved long-latency result is being forced through
    always_comb begin
        pipe_eff    = pipe_we && pipe_wa != 5'd0;
        pipe_accept = !stall_req && pipe_we;
        lu_ready    = stall_req || !pipe_eff;
        lu_hs       = lu_valid && lu_ready;
        pipe_wr     = !stall_req && pipe_eff;
        lu_wr       = lu_hs && lu_wa != 5'd0;
        starving    = lu_valid && !lu_ready;
        issue_ready = outstanding < CNT_W'(MAX_OUTSTANDING);
        issue_acc   = issue_valid && issue_ready;
        set_mask    = (issue_acc && issue_wa != 5'd0) ? 32'd1 << issue_wa : 32'd0;
        clr_mask    = lu_hs ? 32'd1 << lu_wa : 32'd0;
        busy1       = busy[ra1];
        busy2       = busy[ra2];
    end
    // registered write port; address/data only move when a real write is selected
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
        end else begin
            rf_we <= pipe_wr || lu_wr;
            if (pipe_wr || lu_wr) begin
                rf_wa <= pipe_wr ? pipe_wa : lu_wa;
                rf_wd <= pipe_wr ? pipe_wd : lu_wd;
            end
        end
    end
    // starvation: a stall forces lu_ready high, so the forced handshake always lands in the single stall cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve    <= '0;
            stall_req <= 1'b0;
        end else begin
            starve    <= starving ? starve + SW'(1) : '0;
            stall_req <= !stall_req && starving && starve == SW'(STARVE_MAX - 1);
        end
    end
    // scoreboard and in-flight count; a same-edge set overrides the clear, and the count saturates at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy        <= '0;
            outstanding <= '0;
        end else begin
            busy        <= ((busy & ~clr_mask) | set_mask) & ~32'd1;
            outstanding <= (issue_acc && !lu_hs) ? outstanding + CNT_W'(1) :
                           (lu_hs && !issue_acc && outstanding != '0) ? outstanding - CNT_W'(1) : outstanding;
        end
    end
endmodule

// File: tb/tb_wb_arbiter_cp4.sv
// tb_wb_arbiter_cp4: directed and random checks of wb_arbiter_cp4 against a queue-based reference model
module tb_wb_arbiter_cp4;
    localparam int STARVE = 4;
    localparam int MAXO   = 4;
    logic        clk, rst;
    logic        pipe_we, pipe_accept, lu_valid, lu_ready, issue_valid, issue_ready;
    logic        busy1, busy2, stall_req, rf_we;
    logic [4:0]  pipe_wa, lu_wa, issue_wa, ra1, ra2, rf_wa;
    logic [31:0] pipe_wd, lu_wd, rf_wd;
    int          n_chk, n_err;
    logic [31:0] m_busy;
    logic [4:0]  q[$];
    int          m_starve;
    logic        m_stall, m_we, last_hs, last_pacc;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;

    wb_arbiter_cp4 #(.STARVE_MAX(STARVE), .MAX_OUTSTANDING(MAXO), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd), .pipe_accept(pipe_accept),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_wa(lu_wa), .lu_wd(lu_wd),
        .issue_valid(issue_valid), .issue_wa(issue_wa), .issue_ready(issue_ready),
        .ra1(ra1), .ra2(ra2), .busy1(busy1), .busy2(busy2),
        .stall_req(stall_req), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = '0;
        q.delete();
        m_starve = 0;
        m_stall = 1'b0;
        m_we = 1'b0;
        m_wa = '0;
        m_wd = '0;
        last_hs = 1'b0;
        last_pacc = 1'b1;
    endtask

    // check all outputs against the model, then advance one clock and apply the rules to the model
    task automatic tick();
        logic pe, e_acc, e_rdy, e_ir, hs, acc_i, nstall;
        #1;
        pe    = pipe_we && pipe_wa != 5'd0;
        e_acc = !m_stall && pipe_we;
        e_rdy = m_stall || !pe;
        e_ir  = q.size() < MAXO;
        hs    = lu_valid && e_rdy;
        acc_i = issue_valid && e_ir;
        chk("pipe_accept", pipe_accept, e_acc);
        chk("lu_ready", lu_ready, e_rdy);
        chk("issue_ready", issue_ready, e_ir);
        chk("busy1", busy1, m_busy[ra1]);
        chk("busy2", busy2, m_busy[ra2]);
        chk("stall_req", stall_req, m_stall);
        chk("rf_we", rf_we, m_we);
        if (m_we) begin
            chk("rf_wa", rf_wa, m_wa);
            chk("rf_wd", rf_wd, m_wd);
        end
        @(posedge clk);
        if (rst) model_reset();
        else begin
            if (!m_stall && pe) begin
                m_we = 1'b1; m_wa = pipe_wa; m_wd = pipe_wd;
            end else if (hs && lu_wa != 5'd0) begin
                m_we = 1'b1; m_wa = lu_wa; m_wd = lu_wd;
            end else m_we = 1'b0;
            nstall   = m_stall ? !hs : (lu_valid && !e_rdy && m_starve + 1 == STARVE);
            m_starve = (lu_valid && !e_rdy) ? m_starve + 1 : 0;
            m_stall  = nstall;
            if (hs) begin
                m_busy[lu_wa] = 1'b0;
                if (q.size() > 0) void'(q.pop_front());
            end
            if (acc_i) begin
                q.push_back(issue_wa);
                if (issue_wa != 5'd0) m_busy[issue_wa] = 1'b1;
            end
            last_hs   = hs;
            last_pacc = e_acc;
        end
        #1;
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        rst = 1'b1; pipe_we = 1'b0; pipe_wa = '0; pipe_wd = '0;
        lu_valid = 1'b0; lu_wa = '0; lu_wd = '0;
        issue_valid = 1'b0; issue_wa = '0; ra1 = '0; ra2 = '0;
        model_reset();
        tick(); tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("idle_issue_ready", issue_ready, 1'b1);
        // single pipeline write
        pipe_we = 1'b1; pipe_wa = 5'd5; pipe_wd = 32'hDEADBEEF;
        tick();
        pipe_we = 1'b0;
        chk("pw_rf_we", rf_we, 1'b1);
        chk("pw_rf_wa", rf_wa, 5'd5);
        chk("pw_rf_wd", rf_wd, 32'hDEADBEEF);
        tick();
        chk("pw_rf_we_drop", rf_we, 1'b0);
        // long-latency op to x7
        issue_valid = 1'b1; issue_wa = 5'd7;
        tick();
        issue_valid = 1'b0; ra1 = 5'd7;
        tick();
        chk("ll_busy1_set", busy1, 1'b1);
        lu_valid = 1'b1; lu_wa = 5'd7; lu_wd = 32'h12;
        #1 chk("ll_lu_ready", lu_ready, 1'b1);
        tick();
        lu_valid = 1'b0;
        chk("ll_rf_wa", rf_wa, 5'd7);
        chk("ll_rf_wd", rf_wd, 32'h12);
        chk("ll_busy1_clr", busy1, 1'b0);
        tick();
        // starvation of lu by a stream of pipeline writes to x3
        issue_valid = 1'b1; issue_wa = 5'd9;
        tick();
        issue_valid = 1'b0;
        pipe_we = 1'b1; pipe_wa = 5'd3; pipe_wd = 32'h333;
        lu_valid = 1'b1; lu_wa = 5'd9; lu_wd = 32'h99;
        repeat (STARVE) begin
            #1 chk("st_lu_ready_low", lu_ready, 1'b0);
            tick();
        end
        chk("st_stall_req", stall_req, 1'b1);
        chk("st_pipe_accept", pipe_accept, 1'b0);
        chk("st_lu_ready", lu_ready, 1'b1);
        tick();
        lu_valid = 1'b0;
        chk("st_rf_wa_lu", rf_wa, 5'd9);
        chk("st_rf_wd_lu", rf_wd, 32'h99);
        chk("st_stall_drop", stall_req, 1'b0);
        tick();
        pipe_we = 1'b0;
        chk("st_rf_wa_pipe", rf_wa, 5'd3);
        chk("st_rf_wd_pipe", rf_wd, 32'h333);
        tick();
        // x0 pipeline write alongside lu, then set/clear collision on x4
        issue_valid = 1'b1; issue_wa = 5'd10;
        tick();
        issue_wa = 5'd4;
        tick();
        issue_valid = 1'b0;
        pipe_we = 1'b1; pipe_wa = 5'd0; pipe_wd = 32'hBAD;
        lu_valid = 1'b1; lu_wa = 5'd10; lu_wd = 32'hA;
        #1 chk("x0_lu_ready", lu_ready, 1'b1);
        tick();
        pipe_we = 1'b0;
        chk("x0_rf_we", rf_we, 1'b1);
        chk("x0_rf_wa", rf_wa, 5'd10);
        chk("x0_rf_wd", rf_wd, 32'hA);
        lu_wa = 5'd4; lu_wd = 32'h44;
        issue_valid = 1'b1; issue_wa = 5'd4; ra2 = 5'd4;
        tick();
        lu_valid = 1'b0; issue_valid = 1'b0;
        chk("col_busy2", busy2, 1'b1);
        lu_valid = 1'b1; lu_wa = 5'd4; lu_wd = 32'h45;
        tick();
        lu_valid = 1'b0;
        chk("col_busy2_clr", busy2, 1'b0);
        // capacity
        for (int i = 0; i < MAXO; i++) begin
            issue_valid = 1'b1; issue_wa = 5'(11 + i);
            tick();
        end
        chk("cap_issue_ready", issue_ready, 1'b0);
        issue_wa = 5'd15; ra1 = 5'd15;
        tick();
        issue_valid = 1'b0;
        chk("cap_fifth_busy", busy1, 1'b0);
        chk("cap_still_full", issue_ready, 1'b0);
        // asynchronous reset mid-stream
        ra1 = 5'd11;
        pipe_we = 1'b1; pipe_wa = 5'd6; pipe_wd = 32'h66;
        tick();
        pipe_we = 1'b0;
        chk("rst_pre_rf_we", rf_we, 1'b1);
        chk("rst_pre_busy1", busy1, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_rf_wa", rf_wa, 5'd0);
        chk("rst_rf_wd", rf_wd, 32'd0);
        chk("rst_stall", stall_req, 1'b0);
        chk("rst_issue_ready", issue_ready, 1'b1);
        chk("rst_busy1", busy1, 1'b0);
        model_reset();
        tick();
        rst = 1'b0;
        tick();
        // random traffic; lu presents the oldest outstanding op and holds it until accepted
        for (int i = 0; i < 600; i++) begin
            if (last_pacc || !pipe_we) begin
                pipe_we = ($urandom % 4) != 0;
                pipe_wa = 5'($urandom);
                pipe_wd = $urandom;
            end
            if (lu_valid && last_hs) lu_valid = 1'b0;
            if (!lu_valid && q.size() > 0 && ($urandom % 2) == 1) begin
                lu_valid = 1'b1; lu_wa = q[0]; lu_wd = $urandom;
            end
            issue_valid = ($urandom % 3) == 0;
            issue_wa = ($urandom % 8) == 0 ? 5'd0 : 5'($urandom);
            ra1 = 5'($urandom);
            ra2 = ($urandom % 2) == 1 ? issue_wa : 5'($urandom);
            tick();
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/wb_arbiter_cp4.md
Name: wb_arbiter_cp4

Overview:
- Write-back arbiter and scoreboard that drives the single register-file write port (we/wa/wd) of the CP4 core.
- Merges two result sources into that port:
  - the in-order single-cycle pipeline result;
  - a valid/ready long-latency unit (load/mul/div) result.
- Tracks which destination registers have long-latency results outstanding, so decode can stall on RAW hazards.

Parameters:
- STARVE_MAX, 4: consecutive cycles a valid long-latency result may lose arbitration before the pipeline is stalled.
- MAX_OUTSTANDING, 4: maximum long-latency ops in flight.
- CNT_W, 3: width of the outstanding counter; must hold MAX_OUTSTANDING.

Ports:
- clk  input  1  core clock, all state on rising edge
- rst  input  1  asynchronous active-high reset
- pipe_we  input  1  pipeline result write request (this cycle)
- pipe_wa  input  5  pipeline destination register
- pipe_wd  input  32  pipeline result data
- pipe_accept  output  1  pipeline write accepted this cycle (combinational)
- lu_valid  input  1  long-latency result valid
- lu_ready  output  1  long-latency result accepted (combinational)
- lu_wa  input  5  long-latency destination register
- lu_wd  input  32  long-latency result data
- issue_valid  input  1  long-latency op issued this cycle
- issue_wa  input  5  destination of issued op
- issue_ready  output  1  outstanding count < MAX_OUTSTANDING
- ra1, ra2  input  5 each  decode source registers
- busy1, busy2  output  1 each  source has an outstanding long-latency result (combinational)
- stall_req  output  1  registered; pipeline must hold its write
- rf_we  output  1  registered write enable to the register file
- rf_wa  output  5  registered write address
- rf_wd  output  32  registered write data

Behaviour:
- Reset (asynchronous, any cycle):
  - rf_we=0, rf_wa=0, rf_wd=0.
  - busy vector all 0, outstanding count 0, starve counter 0, stall_req=0.
  - In-flight long-latency transactions are discarded; the long-latency unit shares rst.
- Write port timing:
  - rf_* is registered: an accepted write appears on rf_* in the cycle after acceptance, for exactly one cycle.
  - rf_we=0 in any cycle with no accepted non-x0 write.
  - Decode bypasses from rf_wa/rf_wd when rf_we=1.
- Arbitration, per cycle:
  - pipe_eff = pipe_we && pipe_wa!=0.
  - stall_req=0: pipe_accept=pipe_we and lu_ready = !pipe_eff. The pipeline has priority and a write to x0 never blocks the long-latency unit.
  - stall_req=1: pipe_accept=0 and lu_ready=1. The pipeline re-presents the same write next cycle.
  - Selected source drives rf_wa/rf_wd at the next edge.
  - Long-latency write to x0: handshake completes, rf_we stays 0.
- Starve counter:
  - Increments while lu_valid && !lu_ready.
  - Clears on an lu handshake or when !lu_valid.
  - stall_req is set at the edge where the counter reaches STARVE_MAX.
  - stall_req clears at the edge after the lu handshake it forces.
- Scoreboard:
  - 32-bit busy vector.
  - issue_valid && issue_ready && issue_wa!=0 sets busy[issue_wa].
  - lu handshake clears busy[lu_wa].
  - Same register set and cleared in one edge: set wins.
  - busy[0] is constant 0.
  - busy1=busy[ra1] and busy2=busy[ra2] read current state; there is no same-cycle bypass of a set.
- Outstanding counter:
  - +1 per accepted issue (including x0 destinations), −1 per lu handshake.
  - Both in one cycle: unchanged.
  - issue_valid while !issue_ready is ignored, with no state change.
  - The counter never wraps; an lu handshake at count 0 is a protocol error, and the count stays 0.

Test Plan:
- Reset then idle 5 cycles -> rf_we=0, busy1=busy2=0, issue_ready=1, stall_req=0 throughout.
- pipe_we=1, wa=5, wd=0xDEADBEEF, no lu activity -> pipe_accept=1 same cycle; next cycle rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF; following cycle rf_we=0.
- Long-latency op:
  - Issue with wa=7, then ra1=7 -> busy1=1.
  - lu_valid with wa=7, wd=0x12 while pipe idle -> lu_ready=1; next cycle rf_wa=7, rf_wd=0x12; busy1 returns 0.
- Starvation:
  - pipe_eff asserted every cycle (wa=3) while lu_valid (wa=9) held -> lu_ready=0 for STARVE_MAX=4 cycles.
  - Then stall_req=1, pipe_accept=0, lu_ready=1, rf_wa=9 next cycle.
  - stall_req drops and the held pipe write to 3 lands.
- Simultaneous events:
  - pipe_we with wa=0 concurrent with lu_valid -> lu_ready=1 and the lu write lands.
  - issue_wa=4 set and lu_wa=4 clear in the same cycle -> busy[4] stays 1.
- Capacity and reset:
  - 4 issues without completion -> issue_ready=0; a 5th issue is ignored and the count stays 4.
  - Assert rst mid-stream -> all outputs 0 immediately; busy vector and counter cleared.
